// File: rtl/ysyx_22040895_mdu_pkg.sv
// Shared definitions for the RV64 multiply/divide unit: funct3 op codes, FSM states,
// register width and operand-sign helpers.
package ysyx_22040895_mdu_pkg;
  localparam int REG_BUS = 64;  // ysyx_22040895_RegBus

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

  typedef struct packed {
    logic [2:0] op;
    logic       word;
    logic       neg_q;  // product / quotient must be negated
    logic       neg_r;  // remainder must be negated (dividend was negative)
  } mdu_ctl_t;

  // MUL low bits are identical for signed/unsigned, so it is treated as signed.
  function automatic logic op_sgn1(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_sgn2(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction
endpackage

// File: rtl/ysyx_22040895_mdu_iter.sv
// One radix-2 step: shift-add multiply, or restoring shift-subtract divide when
// YSYX_22040895_MDU_DIV_EN is defined. Accumulator is {hi/rem[XLEN:0], lo/quotient[XLEN-1:0]}.
module ysyx_22040895_mdu_iter
  import ysyx_22040895_mdu_pkg::*;
#(
  parameter int XLEN = REG_BUS
) (
  input  logic            div_i,
  input  logic [2*XLEN:0] acc_i,
  input  logic [XLEN-1:0] opnd_i,
  output logic [2*XLEN:0] acc_o
);
  logic [XLEN:0]   hi, sum;
  logic [2*XLEN:0] mul_nxt;

  assign hi      = acc_i[2*XLEN:XLEN];
  assign sum     = hi + (acc_i[0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});
  assign mul_nxt = {1'b0, sum, acc_i[XLEN-1:1]};

`ifdef YSYX_22040895_MDU_DIV_EN
  logic [XLEN:0]   rs, trial;
  logic [2*XLEN:0] div_nxt;

  assign rs      = {hi[XLEN-1:0], acc_i[XLEN-1]};
  assign trial   = rs - {1'b0, opnd_i};
  assign div_nxt = trial[XLEN] ? {rs, acc_i[XLEN-2:0], 1'b0}
                               : {trial, acc_i[XLEN-2:0], 1'b1};
  assign acc_o   = div_i ? div_nxt : mul_nxt;
`else
  logic unused_div;
  assign unused_div = div_i;
  assign acc_o      = mul_nxt;
`endif
endmodule

// File: rtl/ysyx_22040895_mdu.sv
// Multi-cycle RV64 M-extension unit: FSM, counter, operand latches and sign fix-up.
// Divide ops are built only with YSYX_22040895_MDU_DIV_EN; otherwise they report illegal.
module ysyx_22040895_mdu
  import ysyx_22040895_mdu_pkg::*;
#(
  parameter int XLEN = REG_BUS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i_mdu,
  input  logic [2:0]      op_i_mdu,
  input  logic            word_i_mdu,
  input  logic [XLEN-1:0] opnum1_i_mdu,
  input  logic [XLEN-1:0] opnum2_i_mdu,
  input  logic            flush_i_mdu,
  output logic            ready_o_mdu,
  output logic            busy_o_mdu,
  output logic            out_valid_o_mdu,
  output logic [XLEN-1:0] result_o_mdu,
  output logic            illegal_o_mdu
);
  localparam int CNT_W = $clog2(XLEN);

  function automatic logic [XLEN-1:0] wsext(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  mdu_state_e      state;
  mdu_ctl_t        ctl;
  logic [2*XLEN:0] acc, acc_nxt;
  logic [XLEN-1:0] opnd, result_q;
  logic [CNT_W-1:0] cnt;
  logic            out_valid_q, illegal_q;

  logic            sgn1, sgn2, a_neg, b_neg;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;

  always_comb begin
    sgn1 = op_sgn1(op_i_mdu);
    sgn2 = op_sgn2(op_i_mdu);
    if (word_i_mdu) begin
      a_ext = {{(XLEN-32){sgn1 & opnum1_i_mdu[31]}}, opnum1_i_mdu[31:0]};
      b_ext = {{(XLEN-32){sgn2 & opnum2_i_mdu[31]}}, opnum2_i_mdu[31:0]};
    end else begin
      a_ext = opnum1_i_mdu;
      b_ext = opnum2_i_mdu;
    end
    a_neg = sgn1 & a_ext[XLEN-1];
    b_neg = sgn2 & b_ext[XLEN-1];
    a_mag = a_neg ? -a_ext : a_ext;
    b_mag = b_neg ? -b_ext : b_ext;
  end

  ysyx_22040895_mdu_iter #(.XLEN(XLEN)) u_iter (
    .div_i  (ctl.op[2]),
    .acc_i  (acc),
    .opnd_i (opnd),
    .acc_o  (acc_nxt)
  );

  // Final result is formed from the last step's output so it is registered on entry to DONE.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   res_sel, res_fin;

  always_comb begin
    prod    = ctl.word ? (acc_nxt[2*XLEN-1:0] >> 32) : acc_nxt[2*XLEN-1:0];
    prod_s  = ctl.neg_q ? -prod : prod;
    res_sel = (ctl.op == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef YSYX_22040895_MDU_DIV_EN
    if (ctl.op[2]) begin
      if (ctl.op[1]) res_sel = ctl.neg_r ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
      else           res_sel = ctl.neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    end
`endif
    res_fin = wsext(ctl.word, res_sel);
  end

`ifdef YSYX_22040895_MDU_DIV_EN
  logic            div0, ovf, special;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    div0     = (b_ext == '0);
    ovf      = sgn1 && (b_ext == {XLEN{1'b1}}) &&
               (a_ext == (word_i_mdu ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}}));
    special  = op_i_mdu[2] & (div0 | ovf);
    spec_res = div0 ? (op_i_mdu[1] ? a_ext : {XLEN{1'b1}})
                    : (op_i_mdu[1] ? {XLEN{1'b0}} : a_ext);
  end
`else
  logic unused_div;
  assign unused_div = ctl.neg_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ctl         <= '0;
      acc         <= '0;
      opnd        <= '0;
      cnt         <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      if (flush_i_mdu) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (valid_i_mdu) begin
            ctl   <= '{op: op_i_mdu, word: word_i_mdu, neg_q: a_neg ^ b_neg, neg_r: a_neg};
            acc   <= {{(XLEN+1){1'b0}}, b_mag};
            opnd  <= a_mag;
            cnt   <= word_i_mdu ? CNT_W'(31) : CNT_W'(XLEN-1);
            state <= S_CALC;
`ifdef YSYX_22040895_MDU_DIV_EN
            if (op_i_mdu[2]) begin
              acc  <= {{(XLEN+1){1'b0}}, word_i_mdu ? (a_mag << (XLEN-32)) : a_mag};
              opnd <= b_mag;
            end
            if (special) begin
              state       <= S_DONE;
              result_q    <= wsext(word_i_mdu, spec_res);
              out_valid_q <= 1'b1;
            end
`else
            if (op_i_mdu[2]) begin
              state       <= S_DONE;
              result_q    <= '0;
              illegal_q   <= 1'b1;
              out_valid_q <= 1'b1;
            end
`endif
          end
          S_CALC: begin
            acc <= acc_nxt;
            cnt <= cnt - CNT_W'(1);
            if (cnt == '0) begin
              state       <= S_DONE;
              result_q    <= res_fin;
              out_valid_q <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign ready_o_mdu     = (state == S_IDLE) && !rst;
  assign busy_o_mdu      = (state != S_IDLE);
  assign out_valid_o_mdu = out_valid_q & ~flush_i_mdu;
  assign illegal_o_mdu   = illegal_q & ~flush_i_mdu;
  assign result_o_mdu    = result_q;
endmodule

// File: tb/tb_ysyx_22040895_mdu.sv
// Self-checking bench for ysyx_22040895_mdu: directed cases plus random ops against an
// arithmetic reference model; divide expectations follow YSYX_22040895_MDU_DIV_EN.
module tb_ysyx_22040895_mdu;
`ifdef YSYX_22040895_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, word = 1'b0, flush = 1'b0;
  logic [2:0]  op = '0;
  logic [63:0] a = '0, b = '0;
  logic        ready, busy, out_valid, illegal;
  logic [63:0] result;

  int n_chk = 0, n_fail = 0;

  ysyx_22040895_mdu dut (
    .clk             (clk),
    .rst             (rst),
    .valid_i_mdu     (valid),
    .op_i_mdu        (op),
    .word_i_mdu      (word),
    .opnum1_i_mdu    (a),
    .opnum2_i_mdu    (b),
    .flush_i_mdu     (flush),
    .ready_o_mdu     (ready),
    .busy_o_mdu      (busy),
    .out_valid_o_mdu (out_valid),
    .result_o_mdu    (result),
    .illegal_o_mdu   (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference: RISC-V M semantics in plain arithmetic.
  function automatic void ref_op(input logic [2:0] o, input logic w, input logic [63:0] x,
                                 input logic [63:0] y, output logic [63:0] r,
                                 output int lat, output logic ill);
    int sa, sb;
    int unsigned ua, ub;
    longint lsa, lsb;
    logic [31:0] t;
    logic [127:0] px, py, pp;
    bit sp;
    sp = 0; ill = 0; r = '0;
    if (o[2] && !DIV_EN) begin
      ill = 1; lat = 1; return;
    end
    if (w) begin
      sa = x[31:0]; sb = y[31:0]; ua = x[31:0]; ub = y[31:0];
      case (o)
        3'd0: begin t = sa * sb; r = sx32(t); end
        3'd4: if (sb == 0) begin r = '1; sp = 1; end
              else if (sa == int'(32'h8000_0000) && sb == -1) begin r = sx32(x[31:0]); sp = 1; end
              else begin t = sa / sb; r = sx32(t); end
        3'd5: if (ub == 0) begin r = '1; sp = 1; end
              else begin t = ua / ub; r = sx32(t); end
        3'd6: if (sb == 0) begin r = sx32(x[31:0]); sp = 1; end
              else if (sa == int'(32'h8000_0000) && sb == -1) begin r = '0; sp = 1; end
              else begin t = sa % sb; r = sx32(t); end
        3'd7: if (ub == 0) begin r = sx32(x[31:0]); sp = 1; end
              else begin t = ua % ub; r = sx32(t); end
        default: r = '0;
      endcase
    end else begin
      lsa = x; lsb = y;
      case (o)
        3'd0: r = x * y;
        3'd1: begin px = {{64{x[63]}}, x}; py = {{64{y[63]}}, y}; pp = px * py; r = pp[127:64]; end
        3'd2: begin px = {{64{x[63]}}, x}; py = {64'b0, y};       pp = px * py; r = pp[127:64]; end
        3'd3: begin px = {64'b0, x};       py = {64'b0, y};       pp = px * py; r = pp[127:64]; end
        3'd4: if (y == 0) begin r = '1; sp = 1; end
              else if (x == 64'h8000_0000_0000_0000 && y == '1) begin r = x; sp = 1; end
              else r = lsa / lsb;
        3'd5: if (y == 0) begin r = '1; sp = 1; end else r = x / y;
        3'd6: if (y == 0) begin r = x; sp = 1; end
              else if (x == 64'h8000_0000_0000_0000 && y == '1) begin r = '0; sp = 1; end
              else r = lsa % lsb;
        default: if (y == 0) begin r = x; sp = 1; end else r = x % y;
      endcase
    end
    lat = sp ? 1 : (w ? 33 : 65);
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge after the pulse.
  task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                        input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] er, input int el, input logic ei);
    int k;
    bit seen, busy_ok;
    logic [63:0] res;
    logic ill;
    seen = 0; busy_ok = 1; res = 'x; ill = 1'bx; k = 0;
    chk({tag, ":ready"}, ready, 1);
    op = o; word = w; a = x; b = y; valid = 1;
    @(posedge clk); #1 valid = 0;
    while (!seen && k < 100) begin
      @(negedge clk); k++;
      if (!busy) busy_ok = 0;
      if (out_valid) begin seen = 1; res = result; ill = illegal; end
    end
    chk({tag, ":lat"}, seen ? 64'(k) : '1, 64'(el));
    chk({tag, ":res"}, res, er);
    chk({tag, ":ill"}, ill, ei);
    chk({tag, ":busy"}, busy_ok, 1);
    @(negedge clk);
    chk({tag, ":hold"}, {out_valid, result[62:0]}, {1'b0, er[62:0]});
  endtask

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(1, 20));
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] er, x, y;
    logic [2:0] o;
    logic w, ei;
    int el;
    bit bad;

    repeat (2) @(negedge clk);
    chk("rst:ready", ready, 0);
    chk("rst:busy", busy, 0);
    chk("rst:valid", out_valid, 0);
    chk("rst:ill", illegal, 0);
    chk("rst:result", result, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst:ready", ready, 1);
    chk("post_rst:result", result, 0);

    run_op("mul", 3'd0, 0, 64'd7, -64'd3, 64'hFFFF_FFFF_FFFF_FFEB, 65, 0);
    run_op("mulhu", 3'd3, 0, '1, 64'd2, 64'd1, 65, 0);
    run_op("mulh", 3'd1, 0, '1, '1, 64'd0, 65, 0);
    if (DIV_EN) begin
      run_op("divw", 3'd4, 1, -64'd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 33, 0);
      run_op("remw", 3'd6, 1, -64'd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 33, 0);
      run_op("divu0", 3'd5, 0, 64'd12345, 64'd0, '1, 1, 0);
      run_op("rem_ovf", 3'd6, 0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 0);
    end else begin
      run_op("div_ill", 3'd4, 0, 64'd10, 64'd2, 64'd0, 1, 1);
    end

    // Flush mid-operation at cycle 10, new MUL accepted at cycle 11.
    bad = 0;
    op = DIV_EN ? 3'd4 : 3'd0; word = 0; a = 64'd100; b = 64'd7; valid = 1;
    @(posedge clk); #1 valid = 0;
    repeat (9) begin @(negedge clk); if (out_valid) bad = 1; end
    @(negedge clk); flush = 1; #1 if (out_valid) bad = 1;
    @(negedge clk); flush = 0;
    chk("flush:nopulse", bad, 0);
    chk("flush:busy", busy, 0);
    run_op("after_flush", 3'd0, 0, 64'd5, 64'd6, 64'd30, 65, 0);

    // Flush landing on the DONE cycle suppresses the pulse.
    op = 3'd0; word = 0; a = 64'd3; b = 64'd4; valid = 1;
    @(posedge clk); #1 valid = 0;
    repeat (64) @(negedge clk);
    flush = 1; #1 chk("flush_done:pulse", out_valid, 0);
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("flush_done:ready", ready, 1);
    chk("flush_done:valid", out_valid, 0);

    // Reset at cycle 20 of a MUL discards it and clears outputs.
    op = 3'd0; word = 0; a = 64'd9; b = 64'd9; valid = 1;
    @(posedge clk); #1 valid = 0;
    repeat (20) @(negedge clk);
    rst = 1; #1 chk("mid_rst:ready", ready, 0);
    @(negedge clk);
    chk("mid_rst:busy", busy, 0);
    chk("mid_rst:valid", out_valid, 0);
    chk("mid_rst:ill", illegal, 0);
    chk("mid_rst:result", result, 0);
    rst = 0;
    bad = 0;
    repeat (80) begin @(negedge clk); if (out_valid || busy) bad = 1; end
    chk("mid_rst:quiet", bad, 0);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      w = (o == 3'd0 || o[2]) && ($urandom_range(0, 2) == 0);
      x = rnd_val(); y = rnd_val();
      ref_op(o, w, x, y, er, el, ei);
      run_op($sformatf("rnd%0d_op%0d_w%0d", i, o, w), o, w, x, y, er, el, ei);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
